// File: rtl/nukv_ht_mem_responder_if.sv
// Stream bundle between the nukv hash-table read path and its memory responder:
// read commands, in-order read responses and table-population writes.
interface nukv_ht_mem_responder_if #(
  parameter int DATA_WIDTH = 512
);
  logic [31:0]           rdcmd_data;
  logic                  rdcmd_valid;
  logic                  rdcmd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [31:0]           wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;

  modport master (
    output rdcmd_data, rdcmd_valid, rd_ready, wr_addr, wr_data, wr_valid,
    input  rdcmd_ready, rd_data, rd_valid, wr_ready
  );

  modport slave (
    input  rdcmd_data, rdcmd_valid, rd_ready, wr_addr, wr_data, wr_valid,
    output rdcmd_ready, rd_data, rd_valid, wr_ready
  );
endinterface

// File: rtl/nukv_ht_mem_responder.sv
// Single-port RAM bucket responder: clears the table after reset, then serves in-order
// reads with credit-based flow control. Optional counters: define NUKV_MEMRESP_STATS_EN.
module nukv_ht_mem_responder #(
  parameter int DATA_WIDTH      = 512,
  parameter int RAM_ADDR_WIDTH  = 10,
  parameter int MEMADDR_WIDTH   = 21,
  parameter int RAM_LATENCY     = 2,
  parameter int RESP_FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nukv_ht_mem_responder_if.slave bus,
  output logic                   init_done
`ifdef NUKV_MEMRESP_STATS_EN
  ,
  output logic [31:0]            stat_rd_cnt,
  output logic [31:0]            stat_wr_cnt,
  output logic [31:0]            stat_oor_cnt
`endif
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int FIFO_AW   = $clog2(RESP_FIFO_DEPTH);
  localparam int CNT_W     = FIFO_AW + 1;

  if (RAM_ADDR_WIDTH > MEMADDR_WIDTH || RAM_LATENCY < 1 || RAM_LATENCY > 4 ||
      RESP_FIFO_DEPTH < RAM_LATENCY + 1 ||
      (RESP_FIFO_DEPTH & (RESP_FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("nukv_ht_mem_responder: illegal parameter combination");
  end

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                      init_done_q, init_done_d;
  logic [RAM_LATENCY-1:0]    pipe_v_q, pipe_v_d;
  logic [FIFO_AW-1:0]        fifo_wptr_q, fifo_wptr_d, fifo_rptr_q, fifo_rptr_d;
  logic [CNT_W-1:0]          fifo_cnt_q, fifo_cnt_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0]     ram_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]     pipe_data_q [RAM_LATENCY];
  logic [DATA_WIDTH-1:0]     fifo_mem [RESP_FIFO_DEPTH];

  logic                      run_s, rd_in_range_s, wr_in_range_s;
  logic                      rdcmd_ready_s, rd_accept_s, wr_accept_s, push_s, pop_s;
  logic [CNT_W-1:0]          inflight_s, occupancy_s;
  logic                      ram_we_s, ram_re_s;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_s;
  logic [DATA_WIDTH-1:0]     ram_wdata_s;

  assign run_s         = (state_q == ST_RUN);
  assign rd_in_range_s = (bus.rdcmd_data[31:RAM_ADDR_WIDTH] == {(32-RAM_ADDR_WIDTH){1'b0}});
  assign wr_in_range_s = (bus.wr_addr[31:RAM_ADDR_WIDTH] == {(32-RAM_ADDR_WIDTH){1'b0}});

  // The output register counts as an occupied slot so a stalled consumer caps total storage at depth.
  always_comb begin
    inflight_s = {CNT_W{1'b0}};
    for (int i = 0; i < RAM_LATENCY; i++) begin
      inflight_s = inflight_s + CNT_W'(pipe_v_q[i]);
    end
    occupancy_s = fifo_cnt_q + CNT_W'(rd_valid_q) + inflight_s;
  end

  assign rdcmd_ready_s = run_s && !bus.wr_valid && (occupancy_s < CNT_W'(RESP_FIFO_DEPTH));
  assign rd_accept_s   = bus.rdcmd_valid && rdcmd_ready_s;
  assign wr_accept_s   = run_s && bus.wr_valid;
  assign push_s        = pipe_v_q[RAM_LATENCY-1];
  assign pop_s         = (fifo_cnt_q != {CNT_W{1'b0}}) && (!rd_valid_q || bus.rd_ready);

  // Single RAM port arbitration: clear sweep, then writes ahead of reads.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_addr_s  = clr_ptr_q;
    ram_wdata_s = {DATA_WIDTH{1'b0}};
    if (!run_s) begin
      ram_we_s = 1'b1;
    end else if (wr_accept_s && wr_in_range_s) begin
      ram_we_s    = 1'b1;
      ram_addr_s  = bus.wr_addr[RAM_ADDR_WIDTH-1:0];
      ram_wdata_s = bus.wr_data;
    end else if (rd_accept_s && rd_in_range_s) begin
      ram_re_s   = 1'b1;
      ram_addr_s = bus.rdcmd_data[RAM_ADDR_WIDTH-1:0];
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Next-state logic for the FSM, read pipeline, response FIFO and output register.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = run_s;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + RAM_ADDR_WIDTH'(1);
        if (clr_ptr_q == {RAM_ADDR_WIDTH{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase

    pipe_v_d    = pipe_v_q;
    pipe_v_d[0] = rd_accept_s;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
    end

    fifo_wptr_d = push_s ? fifo_wptr_q + FIFO_AW'(1) : fifo_wptr_q;
    fifo_rptr_d = pop_s  ? fifo_rptr_q + FIFO_AW'(1) : fifo_rptr_q;
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);

    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (pop_s) begin
      rd_valid_d = 1'b1;
      rd_data_d  = fifo_mem[fifo_rptr_q];
    end else if (bus.rd_ready) begin
      rd_valid_d = 1'b0;
    end else begin
      rd_valid_d = rd_valid_q;
    end
  end

  // Control state; reset discards everything in flight and restarts the clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= {RAM_ADDR_WIDTH{1'b0}};
      init_done_q <= 1'b0;
      pipe_v_q    <= {RAM_LATENCY{1'b0}};
      fifo_wptr_q <= {FIFO_AW{1'b0}};
      fifo_rptr_q <= {FIFO_AW{1'b0}};
      fifo_cnt_q  <= {CNT_W{1'b0}};
      rd_valid_q  <= 1'b0;
      rd_data_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= init_done_d;
      pipe_v_q    <= pipe_v_d;
      fifo_wptr_q <= fifo_wptr_d;
      fifo_rptr_q <= fifo_rptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Storage datapath; out-of-range or idle slots load zero so no masking is needed later.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_mem[ram_addr_s] <= ram_wdata_s;
    end
    if (ram_re_s) begin
      pipe_data_q[0] <= ram_mem[ram_addr_s];
    end else begin
      pipe_data_q[0] <= {DATA_WIDTH{1'b0}};
    end
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
    if (push_s) begin
      fifo_mem[fifo_wptr_q] <= pipe_data_q[RAM_LATENCY-1];
    end
  end

  assign bus.rdcmd_ready = rdcmd_ready_s;
  assign bus.wr_ready    = wr_accept_s;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign init_done       = init_done_q;

`ifdef NUKV_MEMRESP_STATS_EN
  logic [31:0] stat_rd_cnt_q, stat_rd_cnt_d;
  logic [31:0] stat_wr_cnt_q, stat_wr_cnt_d;
  logic [31:0] stat_oor_cnt_q, stat_oor_cnt_d;

  // Free-running wrap-around counters of accepted and out-of-range commands.
  always_comb begin
    stat_rd_cnt_d  = stat_rd_cnt_q + {31'd0, rd_accept_s};
    stat_wr_cnt_d  = stat_wr_cnt_q + {31'd0, wr_accept_s};
    stat_oor_cnt_d = stat_oor_cnt_q +
                     {31'd0, (rd_accept_s && !rd_in_range_s) || (wr_accept_s && !wr_in_range_s)};
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt_q  <= 32'd0;
      stat_wr_cnt_q  <= 32'd0;
      stat_oor_cnt_q <= 32'd0;
    end else begin
      stat_rd_cnt_q  <= stat_rd_cnt_d;
      stat_wr_cnt_q  <= stat_wr_cnt_d;
      stat_oor_cnt_q <= stat_oor_cnt_d;
    end
  end

  assign stat_rd_cnt  = stat_rd_cnt_q;
  assign stat_wr_cnt  = stat_wr_cnt_q;
  assign stat_oor_cnt = stat_oor_cnt_q;
`endif

endmodule

// File: tb/tb_nukv_ht_mem_responder.sv
// Directed self-checking bench for nukv_ht_mem_responder with default parameters.
module tb_nukv_ht_mem_responder;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_done;
`ifdef NUKV_MEMRESP_STATS_EN
  logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_oor_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] got_q[$];

  nukv_ht_mem_responder_if #(.DATA_WIDTH(DW)) bus ();

  nukv_ht_mem_responder #(
    .DATA_WIDTH(DW), .RAM_ADDR_WIDTH(10), .MEMADDR_WIDTH(21),
    .RAM_LATENCY(2), .RESP_FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .init_done(init_done)
`ifdef NUKV_MEMRESP_STATS_EN
    ,
    .stat_rd_cnt(stat_rd_cnt),
    .stat_wr_cnt(stat_wr_cnt),
    .stat_oor_cnt(stat_oor_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Response capture: every completed handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid && bus.rd_ready) got_q.push_back(bus.rd_data);
  end

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {16{w}};
  endfunction

  function automatic logic [DW-1:0] resp(input int i);
    if (got_q.size() > i) return got_q[i];
    return {DW{1'bx}};
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [DW-1:0] d);
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    bit ok = 1'b0;
    bus.rdcmd_valid = 1'b1; bus.rdcmd_data = a;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (bus.rdcmd_ready === 1'b1) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.rdcmd_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL read_accept: addr %h got accepted=0 required 1", a);
    end
  endtask

  task automatic wait_resp(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_init(output int done_at, output int bad);
    done_at = 0; bad = 0;
    for (int n = 1; n <= 1100; n++) begin
      @(posedge clk); #1;
      if (n <= 1023 && (bus.rdcmd_ready !== 1'b0 || bus.wr_ready !== 1'b0)) bad++;
      if (init_done === 1'b1) begin
        done_at = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int done_at, bad;
    bus.rdcmd_valid = 1'b1; bus.rdcmd_data = 32'h0;
    bus.wr_valid = 1'b1; bus.wr_addr = 32'h8000_0000; bus.wr_data = {DW{1'b0}};
    bus.rd_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.rdcmd_ready !== 1'b0 || bus.wr_ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
        bus.rd_data !== {DW{1'b0}} || init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: rdcmd_ready=%b wr_ready=%b rd_valid=%b rd_data_nz=%b init_done=%b required all 0",
               bus.rdcmd_ready, bus.wr_ready, bus.rd_valid, |bus.rd_data, init_done);
    end
    rst_n = 1'b1;
    wait_init(done_at, bad);
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL ready_during_clear: %0d cycles with a ready high, required 0", bad);
    end
    vectors++;
    if (done_at !== 1025) begin
      miscompares++;
      $display("FAIL init_done_cycle: got %0d required 1025", done_at);
    end
    bus.rdcmd_valid = 1'b0; bus.wr_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_raw_latency();
    do_write(32'h10, {64{8'hA5}});
    bus.rdcmd_valid = 1'b1; bus.rdcmd_data = 32'h10;
    #1;
    vectors++;
    if (bus.rdcmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_write: got %b required 1", bus.rdcmd_ready);
    end
    @(posedge clk); #1;
    bus.rdcmd_data = 32'h11;
    @(posedge clk); #1;
    bus.rdcmd_valid = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_plus1: rd_valid got %b required 0", bus.rd_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_plus2: rd_valid got %b required 0", bus.rd_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== {64{8'hA5}}) begin
      miscompares++;
      $display("FAIL first_resp: valid=%b data=%h required valid=1 data a5..a5", bus.rd_valid, bus.rd_data);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== {DW{1'b0}}) begin
      miscompares++;
      $display("FAIL second_resp: valid=%b data=%h required valid=1 data 0", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_backpressure();
    int p = 0;
    bit acc;
    for (int i = 0; i < 20; i++) do_write(32'(i), pat(i));
    got_q.delete();
    bus.rd_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.rdcmd_valid = 1'b1; bus.rdcmd_data = 32'(p);
      #1 acc = bus.rdcmd_ready;
      @(posedge clk); #1;
      if (acc) p++;
    end
    vectors++;
    if (p !== 8 || bus.rdcmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_limit: accepted %0d ready=%b required 8 and 0", p, bus.rdcmd_ready);
    end
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 100 && p < 20; c++) begin
      bus.rdcmd_valid = 1'b1; bus.rdcmd_data = 32'(p);
      #1 acc = bus.rdcmd_ready;
      @(posedge clk); #1;
      if (acc) p++;
    end
    bus.rdcmd_valid = 1'b0;
    wait_resp(20, 100);
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (got_q.size() !== 20) begin
      miscompares++;
      $display("FAIL bp_count: got %0d responses required 20", got_q.size());
    end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (resp(i) !== pat(i)) begin
        miscompares++;
        $display("FAIL bp_order[%0d]: got %h required %h", i, resp(i), pat(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    got_q.delete();
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.rdcmd_valid = 1'b1; bus.rdcmd_data = 32'(k);
      #1 if (bus.rdcmd_ready !== 1'b1) stalls++;
      @(posedge clk); #1;
    end
    bus.rdcmd_valid = 1'b0;
    vectors++;
    if (stalls !== 0) begin
      miscompares++;
      $display("FAIL b2b_stall: %0d stalled cycles required 0", stalls);
    end
    wait_resp(6, 30);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (resp(k) !== pat(k)) begin
        miscompares++;
        $display("FAIL b2b_data[%0d]: got %h required %h", k, resp(k), pat(k));
      end
    end
  endtask

  task automatic test_out_of_range();
`ifdef NUKV_MEMRESP_STATS_EN
    logic [31:0] oor_before;
    oor_before = stat_oor_cnt;
`endif
    do_write(32'h3FF, {DW{1'b1}});
    do_write(32'h400, {16{32'hDEAD_BEEF}});
    got_q.delete();
    do_read(32'h400);
    do_read(32'h1F_FFFF);
    do_read(32'h0);
    wait_resp(3, 40);
    vectors++;
    if (resp(0) !== {DW{1'b0}}) begin
      miscompares++;
      $display("FAIL oor_read_400: got %h required 0", resp(0));
    end
    vectors++;
    if (resp(1) !== {DW{1'b0}}) begin
      miscompares++;
      $display("FAIL oor_read_1fffff: got %h required 0", resp(1));
    end
    vectors++;
    if (resp(2) !== pat(0)) begin
      miscompares++;
      $display("FAIL oor_write_dropped: got %h required %h", resp(2), pat(0));
    end
`ifdef NUKV_MEMRESP_STATS_EN
    vectors++;
    if (stat_oor_cnt !== oor_before + 32'd3) begin
      miscompares++;
      $display("FAIL stat_oor: got %0d required %0d", stat_oor_cnt, oor_before + 32'd3);
    end
`endif
  endtask

  task automatic test_write_priority();
    int bad = 0;
    got_q.delete();
    bus.wr_valid = 1'b1; bus.rdcmd_valid = 1'b1; bus.rdcmd_data = 32'h22;
    for (int k = 0; k < 3; k++) begin
      bus.wr_addr = 32'h20 + 32'(k); bus.wr_data = pat(100 + k);
      #1 if (bus.rdcmd_ready !== 1'b0 || bus.wr_ready !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL write_priority: %0d bad cycles required 0", bad);
    end
    #1;
    vectors++;
    if (bus.rdcmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL read_after_writes_ready: got %b required 1", bus.rdcmd_ready);
    end
    @(posedge clk); #1;
    bus.rdcmd_valid = 1'b0;
    do_read(32'h20);
    do_read(32'h21);
    wait_resp(3, 30);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (resp(k) !== pat(100 + ((k + 2) % 3))) begin
        miscompares++;
        $display("FAIL prio_data[%0d]: got %h required %h", k, resp(k), pat(100 + ((k + 2) % 3)));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int done_at, bad;
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) do_read(32'h20 + 32'(k % 3));
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_before_reset: rd_valid got %b required 1", bus.rd_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== {DW{1'b0}} || init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: rd_valid=%b rd_data_nz=%b init_done=%b required 0 0 0",
               bus.rd_valid, |bus.rd_data, init_done);
    end
    bus.rd_ready = 1'b1;
    got_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init(done_at, bad);
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (done_at !== 1025 || got_q.size() !== 0) begin
      miscompares++;
      $display("FAIL reinit: init after %0d cycles, %0d stale responses, required 1025 and 0", done_at, got_q.size());
    end
    do_read(32'h20);
    wait_resp(1, 20);
    vectors++;
    if (resp(0) !== {DW{1'b0}}) begin
      miscompares++;
      $display("FAIL recleared: got %h required 0", resp(0));
    end
  endtask

  initial begin
    test_reset();
    test_raw_latency();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_write_priority();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
